// File: rtl/ram_sync_moc.sv
// ram_sync_moc: clocked big-endian byte-addressed data RAM with a registered
// four-phase MOV/MOC handshake, a programmable wait-state count and optional
// sign extension on byte/halfword reads.
// Optional feature: define RAM_MISALIGN_FAULT_EN to flag misaligned halfword/word
// accesses (no write, DataOut held, Fault=1) instead of forcing alignment.
module ram_sync_moc #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mov_i,
  input  logic        read_write_i,
  input  logic [2:0]  ms_2_0_i,
  input  logic [31:0] data_in_i,
  input  logic [31:0] address_i,
  input  logic        moc_off_i,
  output logic        moc_o,
  output logic [31:0] data_out_o,
  output logic        busy_o,
  output logic        fault_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } state_e;

  state_e      state_q, state_d;
  addr_t       addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [2:0]  ms_q, ms_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        moc_q, moc_d;
  logic [31:0] data_out_q, data_out_d;
  logic        fault_q, fault_d;

  logic [7:0]  mem [Depth];

  addr_t       base;
  addr_t       a0, a1, a2, a3;
  logic        misalign;
  logic        size_ok;
  logic        access;
  logic        do_read;
  logic        do_write;
  logic        fill;
  logic [31:0] rdata;

  // Upper address bits are deliberately ignored so accesses wrap modulo Depth.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address_i[31:ADDR_WIDTH];

  // Effective base address: forced alignment unless misalignment is reported.
  always_comb begin
    base = addr_q;
`ifndef RAM_MISALIGN_FAULT_EN
    if (ms_q[1:0] == 2'b01) base[0] = 1'b0;
    if (ms_q[1:0] == 2'b10) base[1:0] = 2'b00;
`endif
  end

  assign a0 = base;
  assign a1 = base + addr_t'(1);
  assign a2 = base + addr_t'(2);
  assign a3 = base + addr_t'(3);

`ifdef RAM_MISALIGN_FAULT_EN
  assign misalign = ((ms_q[1:0] == 2'b01) && addr_q[0]) ||
                    ((ms_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign size_ok  = (ms_q[1:0] != 2'b11);
  assign access   = (state_q == StWait) && (cnt_q == 4'd0);
  assign do_read  = access && rw_q && size_ok && !misalign;
  assign do_write = access && !rw_q && size_ok && !misalign;

  // Big-endian read assembly with optional sign fill from the first byte.
  always_comb begin
    fill  = ms_q[2] & mem[a0][7];
    rdata = data_out_q;
    unique case (ms_q[1:0])
      2'b00:   rdata = {{24{fill}}, mem[a0]};
      2'b01:   rdata = {{16{fill}}, mem[a0], mem[a1]};
      2'b10:   rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};
      default: rdata = data_out_q;
    endcase
  end

  // State and handshake registers; reset abandons any pending access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      ms_q       <= 3'b000;
      wdata_q    <= 32'h0;
      cnt_q      <= 4'd0;
      moc_q      <= 1'b0;
      data_out_q <= 32'h0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      ms_q       <= ms_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      moc_q      <= moc_d;
      data_out_q <= data_out_d;
      fault_q    <= fault_d;
    end
  end

  // Next-state logic; DONE only exits once the master drops MOV.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (mov_i) state_d = StWait;
      StWait:  if (cnt_q == 4'd0) state_d = StDone;
      StDone:  if (!mov_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and handshake next values per state.
  always_comb begin
    addr_d     = addr_q;
    rw_d       = rw_q;
    ms_d       = ms_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    moc_d      = moc_q;
    data_out_d = data_out_q;
    fault_d    = fault_q;
    unique case (state_q)
      StIdle: begin
        if (mov_i) begin
          addr_d  = address_i[ADDR_WIDTH-1:0];
          rw_d    = read_write_i;
          ms_d    = ms_2_0_i;
          wdata_d = data_in_i;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          moc_d   = 1'b1;
          fault_d = misalign;
          if (do_read) data_out_d = rdata;
        end
      end
      StDone: begin
        // MOCoff clears MOC early but the FSM waits for MOV low.
        if (moc_off_i || !mov_i) begin
          moc_d   = 1'b0;
          fault_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Storage array: no reset, big-endian byte lanes.
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      unique case (ms_q[1:0])
        2'b00: mem[a0] <= wdata_q[7:0];
        2'b01: begin
          mem[a0] <= wdata_q[15:8];
          mem[a1] <= wdata_q[7:0];
        end
        2'b10: begin
          mem[a0] <= wdata_q[31:24];
          mem[a1] <= wdata_q[23:16];
          mem[a2] <= wdata_q[15:8];
          mem[a3] <= wdata_q[7:0];
        end
        default: ;
      endcase
    end
  end

  assign moc_o      = moc_q;
  assign data_out_o = data_out_q;
  assign busy_o     = (state_q != StIdle);
  assign fault_o    = fault_q;

endmodule
